// File: rtl/line_fill_engine.sv
// Cache-miss line fill sequencer: optional victim writeback burst, then line read burst.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the read burst at req_word and wraps.
module line_fill_engine #(
  parameter int mem_depth  = 32,
  parameter int data_width = 32,
  parameter int line_words = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic [$clog2(mem_depth)-$clog2(line_words)-1:0]       req_line,
  input  logic                                                  req_wb,
  input  logic [$clog2(mem_depth)-$clog2(line_words)-1:0]       req_wb_line,
  input  logic [$clog2(line_words)-1:0]                         req_word,
  output logic [$clog2(line_words)-1:0]                         wb_idx,
  input  logic [data_width-1:0]                                 wb_data,
  output logic                                                  fill_valid,
  output logic [$clog2(line_words)-1:0]                         fill_idx,
  output logic [data_width-1:0]                                 fill_data,
  output logic                                                  done,
  output logic [$clog2(mem_depth)-1:0]                          mem_raddr,
  output logic                                                  mem_ren,
  input  logic                                                  mem_rready,
  input  logic [data_width-1:0]                                 mem_rdata,
  input  logic                                                  mem_rdata_valid,
  output logic [$clog2(mem_depth)-1:0]                          mem_waddr,
  output logic                                                  mem_wen,
  input  logic                                                  mem_wready,
  output logic [data_width-1:0]                                 mem_wdata
);
  localparam int AW = $clog2(mem_depth);
  localparam int LW = $clog2(line_words);
  localparam int LA = AW - LW;
  localparam logic [LW:0] NWORDS = (LW+1)'(line_words);

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

  state_t          state_q, state_d;
  logic [LA-1:0]   line_q, line_d;
  logic [LA-1:0]   wb_line_q, wb_line_d;
  logic [LW-1:0]   wcnt_q, wcnt_d;
  logic [LW-1:0]   icnt_q, icnt_d;
  logic [LW:0]     issued_q, issued_d;
  logic [LW-1:0]   rcnt_q, rcnt_d;
  logic [LW-1:0]   ridx_q, ridx_d;
  logic [LW-1:0]   start_word;

`ifdef CRITICAL_WORD_FIRST_EN
  always_comb start_word = req_word;
`else
  logic unused_req_word;
  always_comb begin
    start_word      = '0;
    unused_req_word = ^req_word;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      wb_line_q <= '0;
      wcnt_q    <= '0;
      icnt_q    <= '0;
      issued_q  <= '0;
      rcnt_q    <= '0;
      ridx_q    <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      wb_line_q <= wb_line_d;
      wcnt_q    <= wcnt_d;
      icnt_q    <= icnt_d;
      issued_q  <= issued_d;
      rcnt_q    <= rcnt_d;
      ridx_q    <= ridx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    wb_line_d = wb_line_q;
    wcnt_d    = wcnt_q;
    icnt_d    = icnt_q;
    issued_d  = issued_q;
    rcnt_d    = rcnt_q;
    ridx_d    = ridx_q;

    req_ready  = (state_q == IDLE);
    done       = (state_q == DONE);
    mem_wen    = (state_q == WB);
    mem_ren    = (state_q == RD) && (issued_q < NWORDS);
    // Returns only count while reading, so a return still in flight across reset is dropped.
    fill_valid = (state_q == RD) && mem_rdata_valid;

    wb_idx    = wcnt_q;
    mem_waddr = mem_wen ? {wb_line_q, wcnt_q} : '0;
    mem_wdata = mem_wen ? wb_data : '0;
    mem_raddr = mem_ren ? {line_q, icnt_q} : '0;
    fill_idx  = fill_valid ? ridx_q : '0;
    fill_data = fill_valid ? mem_rdata : '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          line_d    = req_line;
          wb_line_d = req_wb_line;
          wcnt_d    = '0;
          icnt_d    = start_word;
          ridx_d    = start_word;
          issued_d  = '0;
          rcnt_d    = '0;
          state_d   = req_wb ? WB : RD;
        end
      end
      WB: begin
        if (mem_wready) begin
          wcnt_d = wcnt_q + LW'(1);
          if (wcnt_q == '1) state_d = RD;
        end
      end
      RD: begin
        if (mem_ren && mem_rready) begin
          icnt_d   = icnt_q + LW'(1);
          issued_d = issued_q + (LW+1)'(1);
        end
        if (fill_valid) begin
          ridx_d = ridx_q + LW'(1);
          rcnt_d = rcnt_q + LW'(1);
          if (rcnt_q == '1) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_line_fill_engine.sv
// Scoreboard bench for line_fill_engine: behavioural memory model predicts writes, reads and fills.
module tb_line_fill_engine;
  localparam int MD = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int AW = $clog2(MD);
  localparam int LW = $clog2(N);
  localparam int LA = AW - LW;

  logic          clk = 0;
  logic          rst;
  logic          req_valid, req_ready, req_wb;
  logic [LA-1:0] req_line, req_wb_line;
  logic [LW-1:0] req_word, wb_idx, fill_idx;
  logic [DW-1:0] wb_data, fill_data, mem_rdata, mem_wdata;
  logic          fill_valid, done;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_ren, mem_rready, mem_rdata_valid, mem_wen, mem_wready;

  line_fill_engine #(.mem_depth(MD), .data_width(DW), .line_words(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line), .req_wb(req_wb), .req_wb_line(req_wb_line), .req_word(req_word),
    .wb_idx(wb_idx), .wb_data(wb_data), .fill_valid(fill_valid), .fill_idx(fill_idx),
    .fill_data(fill_data), .done(done), .mem_raddr(mem_raddr), .mem_ren(mem_ren),
    .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wready(mem_wready), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issue  = 0;

  logic [DW-1:0] refmem [MD];
  logic [DW-1:0] smem   [MD];
  logic [DW-1:0] victim [N];
  logic [63:0]   wq[$];
  logic [63:0]   rq[$];
  logic [63:0]   fq[$];
  int            dq[$];

  assign wb_data = victim[wb_idx];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, inout logic [63:0] q[$], input logic [63:0] act);
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  // memory controller stub
  int   rdy_mode = 0;
  int   hold     = 0;
  bit   first_pend = 0;
  logic pend_n = 0;
  logic [AW-1:0] paddr = '0;

  always @(negedge clk) begin
    if (rst) begin
      pend_n = 0;
    end else begin
      pend_n = mem_ren && mem_rready;
      paddr  = mem_raddr;
      if (mem_wen && mem_wready) smem[mem_waddr] = mem_wdata;
      if (rdy_mode == 2 && first_pend && mem_ren && mem_rready) begin
        hold = 3;
        first_pend = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rdata_valid = pend_n;
    mem_rdata = pend_n ? smem[paddr] : DW'($urandom);
    case (rdy_mode)
      0: begin mem_rready = 1; mem_wready = 1; end
      1: begin mem_rready = ($urandom_range(0, 3) != 0); mem_wready = ($urandom_range(0, 2) != 0); end
      default: begin
        mem_wready = ~mem_wready;
        if (hold > 0) begin mem_rready = 0; hold--; end
        else mem_rready = 1;
      end
    endcase
  end

  // monitor
  logic          prev_rstall = 0, prev_wstall = 0;
  logic [AW-1:0] prev_raddr, prev_waddr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    if (rst) begin
      prev_rstall = 0;
      prev_wstall = 0;
    end else begin
      if (mem_ren && mem_wen) check("ren_wen_exclusive", 1, 0);
      if (prev_rstall) check("raddr_held", {mem_ren, 32'(mem_raddr)}, {1'b1, 32'(prev_raddr)});
      if (prev_wstall) check("waddr_held", {mem_wen, 27'(mem_waddr), mem_wdata},
                             {1'b1, 27'(prev_waddr), prev_wdata});
      if (mem_wen && mem_wready) pop_check("write", wq, (64'(mem_waddr) << 32) | 64'(mem_wdata));
      if (mem_ren && mem_rready) begin
        n_issue++;
        pop_check("raddr", rq, 64'(mem_raddr));
      end
      if (fill_valid) pop_check("fill", fq, (64'(fill_idx) << 32) | 64'(fill_data));
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", 1, 0);
        else void'(dq.pop_front());
        check("done_fills_left", 64'(fq.size() + wq.size() + rq.size()), 0);
      end
      prev_rstall = mem_ren && !mem_rready;
      prev_raddr  = mem_raddr;
      prev_wstall = mem_wen && !mem_wready;
      prev_waddr  = mem_waddr;
      prev_wdata  = mem_wdata;
    end
  end

  // reference model: expected bus traffic for one request
  task automatic model_req(input int line, input bit wb, input int wbl, input int word);
    int start;
`ifdef CRITICAL_WORD_FIRST_EN
    start = word;
`else
    start = 0;
`endif
    for (int i = 0; i < N; i++) victim[i] = $urandom;
    if (wb) begin
      for (int i = 0; i < N; i++) begin
        wq.push_back((64'(wbl * N + i) << 32) | 64'(victim[i]));
        refmem[wbl * N + i] = victim[i];
      end
    end
    for (int k = 0; k < N; k++) begin
      int idx = (start + k) % N;
      int a   = line * N + idx;
      rq.push_back(64'(a));
      fq.push_back((64'(idx) << 32) | 64'(refmem[a]));
    end
    dq.push_back(1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 300);
    if (!req_ready) begin
      check("idle_timeout", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "engine stuck busy");
    end
  endtask

  task automatic drive_req(input int line, input bit wb, input int wbl, input int word);
    @(posedge clk); #1;
    req_valid = 1; req_line = LA'(line); req_wb = wb; req_wb_line = LA'(wbl); req_word = LW'(word);
    @(negedge clk);
    check("accept_ready", req_ready, 1);
  endtask

  task automatic do_req(input int line, input bit wb, input int wbl, input int word, input int exp_lat);
    int n = 0;
    bit got = 0;
    wait_idle();
    model_req(line, wb, wbl, word);
    drive_req(line, wb, wbl, word);
    @(posedge clk); #1;
    req_line = LA'($urandom); req_wb = 1'($urandom); req_wb_line = LA'($urandom); req_word = LW'($urandom);
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (n <= 2) check("busy_ready_low", req_ready, 0);
      got = done;
      @(posedge clk); #1;
      if (n >= 2) req_valid = 0;
    end
    req_valid = 0;
    if (!got) check("done_timeout", 0, 1);
    else if (exp_lat > 0) check("done_latency", 64'(n), 64'(exp_lat));
  endtask

  initial begin
    rst = 1; req_valid = 0; req_line = '0; req_wb = 0; req_wb_line = '0; req_word = '0;
    mem_rready = 1; mem_wready = 1; mem_rdata_valid = 0; mem_rdata = '0;
    for (int i = 0; i < MD; i++) begin
      refmem[i] = $urandom;
      smem[i]   = refmem[i];
    end
    for (int i = 0; i < N; i++) victim[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_outs", {mem_ren, mem_wen, fill_valid, done, wb_idx, fill_idx}, '0);
    check("rst_addrs", {mem_raddr, mem_waddr, fill_data, mem_wdata}, '0);
    @(posedge clk); #1 rst = 0;

    rdy_mode = 0;
    do_req(3, 0, 0, 0, N + 2);
    do_req(5, 1, 1, 0, 2 * N + 2);
    rdy_mode = 2; first_pend = 1;
    do_req(2, 1, 6, 0, 0);
    rdy_mode = 0;
    do_req(7, 0, 0, 1, N + 2);
    do_req(2, 0, 0, 3, N + 2);

    // asynchronous reset in the middle of a read burst
    wait_idle();
    model_req(4, 0, 0, 0);
    drive_req(4, 0, 0, 0);
    @(posedge clk); #1 req_valid = 0;
    n_issue = 0;
    for (int i = 0; i < 20 && n_issue < 2; i++) @(negedge clk);
    check("rst_mid_issues", 64'(n_issue >= 2), 1);
    #2 rst = 1;
    #1;
    check("rst_mid_outs", {req_ready, mem_ren, mem_wen, fill_valid, done}, 5'b10000);
    wq.delete(); rq.delete(); fq.delete(); dq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    do_req(4, 0, 0, 2, N + 2);

    rdy_mode = 1;
    for (int t = 0; t < 25; t++)
      do_req($urandom_range(0, MD / N - 1), 1'($urandom), $urandom_range(0, MD / N - 1),
             $urandom_range(0, N - 1), 0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("queues_empty", 64'(wq.size() + rq.size() + fq.size() + dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
